// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Brief    : Execute-stage condition/flag unit. Holds the NZCV register,
//            evaluates the ARM condition code against it, gates the decoder
//            write enables and keeps executed/skipped instruction counters.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic             Carry,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ex;
    logic w_retire;
    logic w_upd_nz;
    logic w_upd_cv;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition decode from the registered flags only; the writing
    // instruction never sees its own ALU result.
    always_comb begin
        w_cond_ex = 1'b1;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;   // AL, and 1111 treated as always
        endcase
    end

    // A stalled instruction is re-presented next cycle, so it only retires
    // (updates flags/counters) once the stall releases.
    assign w_retire = ~Stall & ~Flush & ~Reset;
    assign w_upd_nz = w_retire & w_cond_ex & FlagW[1];
    assign w_upd_cv = w_retire & w_cond_ex & FlagW[0];

    // Write enables are not gated by Stall: repeating an identical write
    // while the stage is held is harmless.
    assign CondEx    = w_cond_ex;
    assign PCSrc     = PCS & w_cond_ex & ~Flush;
    assign RegWrite  = RegW & ~NoWrite & w_cond_ex & ~Flush;
    assign MemWrite  = MemW & w_cond_ex & ~Flush;
    assign Carry     = r_flags[1];
    assign Flags     = r_flags;
    assign ExecCount = r_exec_cnt;
    assign SkipCount = r_skip_cnt;

    // NZCV register: N,Z and C,V pairs update independently.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_upd_nz) r_flags[3:2] <= ALUFlags[3:2];
            if (w_upd_cv) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Retired-instruction counters; exactly one bumps per retire, wrapping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_retire) begin
            if (w_cond_ex) r_exec_cnt <= r_exec_cnt + c_one;
            else           r_skip_cnt <= r_skip_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit
// Brief    : Self-checking bench for cond_unit (CNT_W=4 to exercise wrap).
//            Directed steps followed by randomized cycles, each compared
//            against a behavioural NZCV/counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             Reset, Stall, Flush;
    logic [3:0]       Cond, ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             PCSrc, RegWrite, MemWrite, CondEx, Carry;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount, SkipCount;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_skip;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Carry(Carry), .Flags(Flags),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ARM-style evaluation: even codes test a base predicate, odd codes
    // invert it; 1111 is always-true.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b1;
        if (c == 4'hE) return 1'b1;
        return base ^ c[0];
    endfunction

    // One instruction cycle: drive, check combinational outputs, clock,
    // advance the model, check registered state. Entered just after posedge.
    task automatic step(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                        input logic pcs, input logic regw, input logic memw, input logic nowr,
                        input logic stall, input logic flush, input logic rst);
        bit pass;
        Cond = cond; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw;
        MemW = memw; NoWrite = nowr; Stall = stall; Flush = flush; Reset = rst;
        #1;
        pass = cond_pass(cond, m_flags);
        chk("condex",   32'(CondEx),   32'(pass));
        chk("pcsrc",    32'(PCSrc),    32'(pcs && pass && !flush));
        chk("regwrite", 32'(RegWrite), 32'(regw && !nowr && pass && !flush));
        chk("memwrite", 32'(MemWrite), 32'(memw && pass && !flush));
        @(posedge CLK);
        #1;
        if (rst) begin
            m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        end else if (!stall && !flush) begin
            if (pass) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
                m_exec = (m_exec + 1) % (1 << CNT_W);
            end else begin
                m_skip = (m_skip + 1) % (1 << CNT_W);
            end
        end
        chk("flags", 32'(Flags), 32'(m_flags));
        chk("carry", 32'(Carry), 32'(m_flags[1]));
        chk("exec",  32'(ExecCount), 32'(m_exec));
        chk("skip",  32'(SkipCount), 32'(m_skip));
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Cond = 4'h1; ALUFlags = 4'hF;
        FlagW = 2'b11; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        @(posedge CLK); #1;
        m_flags = 4'b0000; m_exec = 0; m_skip = 0;

        // Reset held with flag writes requested
        step(4'h1, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 1);
        step(4'h1, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_flags", 32'(Flags), 32'h0);
        chk("rst_exec",  32'(ExecCount), 32'h0);
        Reset = 1'b0; Cond = 4'h1; #1;
        chk("rst_ne_condex", 32'(CondEx), 32'h1);

        // AL writes Z,C
        step(4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("al_flags", 32'(Flags), 32'h6);
        chk("al_carry", 32'(Carry), 32'h1);
        step(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0);   // EQ passes
        step(4'h8, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0);   // HI fails
        chk("hi_skip", 32'(SkipCount), 32'h1);

        // N,Z only
        step(4'hE, 4'b1001, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        chk("nz_flags", 32'(Flags), 32'hA);
        step(4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);   // GE fails
        step(4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);   // LT passes

        // Failed EQ with memory write and flag write request
        step(4'h0, 4'b0101, 2'b11, 0, 0, 1, 0, 0, 0, 0);
        chk("eqfail_flags", 32'(Flags), 32'hA);
        // NoWrite compare updates flags
        step(4'hE, 4'b0101, 2'b11, 0, 1, 0, 1, 0, 0, 0);
        chk("cmp_flags", 32'(Flags), 32'h5);

        // Stall 3 cycles then release
        for (int i = 0; i < 3; i++) step(4'hE, 4'b0010, 2'b01, 0, 1, 0, 0, 1, 0, 0);
        chk("stall_flags", 32'(Flags), 32'h5);
        step(4'hE, 4'b0010, 2'b01, 0, 1, 0, 0, 0, 0, 0);
        chk("release_flags", 32'(Flags), 32'h6);
        // Flush, and Stall+Flush together
        step(4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1, 0);
        step(4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1, 0);
        chk("flush_flags", 32'(Flags), 32'h6);

        // Counter wrap
        step(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) step(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("exec_15", 32'(ExecCount), 32'hF);
        step(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("exec_wrap", 32'(ExecCount), 32'h0);
        for (int i = 0; i < 3; i++) step(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step(4'h0, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 0);   // fail -> skip
        step(4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 0, 0, 1);   // reset beats retire
        chk("midrst_exec", 32'(ExecCount), 32'h0);
        chk("midrst_skip", 32'(SkipCount), 32'h0);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition and flag unit; sits directly downstream of the ALU and consumes its ALUFlags.
- Holds the architectural NZCV register with per-field update enables. Evaluates the instruction's 4-bit ARM condition code against the registered flags.
- Gates PC/register/memory write enables from the decoder, and feeds the registered C flag back to the ALU Carry input.
- Keeps executed/skipped instruction counters for performance debug.

Parameters:
- CNT_W, 32, width of the ExecCount and SkipCount counters.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  EX stage held this cycle; no state update.
- Flush  input  1  EX stage holds a bubble; instruction squashed.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from ALU for the current instruction.
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  decoder: CMP/CMN/TST/TEQ; register write suppressed.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed for the current instruction.
- Carry  output  1  registered C flag; drives the ALU Carry input.
- Flags  output  4  registered {N,Z,C,V}.
- ExecCount  output  CNT_W  instructions retired with CondEx=1.
- SkipCount  output  CNT_W  instructions retired with CondEx=0.

Behaviour:
- Reset (sync, on rising CLK with Reset=1):
  - Flags=4'b0000, so Carry=0.
  - ExecCount=0, SkipCount=0.
  - The combinational outputs follow from the reset flags.
  - Reset wins over every other input in the same cycle.
- Condition decode (combinational, from registered flags only; never from ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is treated as 1.
- Gated outputs (combinational, zero latency):
  - PCSrc = PCS & CondEx & !Flush.
  - RegWrite = RegW & !NoWrite & CondEx & !Flush.
  - MemWrite = MemW & CondEx & !Flush.
  - Stall does not gate these outputs; repeating an identical write is harmless.
- Retire qualifier:
  - Retire = !Stall & !Flush & !Reset.
- Flag update, registered with 1-cycle latency:
  - If Retire & CondEx & FlagW[1], then {N,Z} <= ALUFlags[3:2].
  - If Retire & CondEx & FlagW[0], then {C,V} <= ALUFlags[1:0].
  - The fields update independently. Unselected fields hold.
  - A failed condition never updates flags.
  - Flags written in cycle t are visible to Cond evaluation and Carry in cycle t+1. No bypass: the instruction writing the flags does not see its own result.
- Stall:
  - Blocks the flag update and the counter increments, so ADC/SBC under stall do not double-consume carry.
- Flush:
  - Blocks everything: gated outputs, flags and counters.
- Counters, on Retire:
  - ExecCount+1 if CondEx, else SkipCount+1. Exactly one increments per retired instruction.
  - Counters wrap modulo 2^CNT_W (all-ones -> 0). They do not saturate.
- Stall and Flush both high: behaves as Flush.

Test Plan:
- Reset=1 for 2 cycles with ALUFlags=4'b1111, FlagW=2'b11 -> Flags=0000, Carry=0, counters 0. Cond=0001 (NE) -> CondEx=1.
- Cond=1110, FlagW=11, ALUFlags=0110 (Z,C) -> next cycle Flags=0110, Carry=1. Then Cond=0000 with RegW=1 -> RegWrite=1; Cond=1000 (HI) -> CondEx=0, RegWrite=0.
- From Flags=0110, Cond=1110, FlagW=10, ALUFlags=1001 -> Flags=1010 (N,Z replaced; C,V kept). Then Cond=1010 (GE) -> CondEx=0; Cond=1011 (LT) -> 1.
- Cond=0000 with Z=0, FlagW=11, MemW=1 -> MemWrite=0, Flags unchanged, SkipCount+1. Same with Cond=1110, NoWrite=1, RegW=1 -> RegWrite=0, flags updated, ExecCount+1.
- Stall=1 for 3 cycles with FlagW=01, ALUFlags=0010 -> Flags and counters frozen. Release -> single update, ExecCount+1. Flush=1 with PCS=1 -> PCSrc=0, no update.
- CNT_W=4: retire 16 AL instructions -> ExecCount 15 -> 0 wrap. Reset asserted mid-sequence alongside Retire -> counters 0 next cycle.
